// File: rtl/ram_pkg.sv
// Dataset RAM geometry shared by the RAM and its read-side streamer:
// row layout, address width and the index of the y field within a row.
package ram_pkg;
    localparam int ADDR_WIDTH   = 12;
    localparam int MAX_FEATURES = 15;
    localparam int LENGTH       = 16;
    localparam int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);
    localparam int FIELD_W      = 4;

    localparam logic [FIELD_W-1:0] Y_FIELD = FIELD_W'(MAX_FEATURES);

    // Feature counts above the row capacity clamp to the capacity.
    function automatic logic [FIELD_W-1:0] sat_features(input logic [FIELD_W-1:0] n);
        return ({1'b0, n} > {1'b0, Y_FIELD}) ? Y_FIELD : n;
    endfunction
endpackage

// File: rtl/ram_row_streamer_if.sv
// Field stream from the row streamer to the regression datapath.
// valid/ready: a beat moves on a rising edge where out_valid and out_ready are both 1;
// while out_valid=1 and out_ready=0 every out_* signal holds, and out_valid never looks at out_ready.
interface ram_row_streamer_if;
    import ram_pkg::*;

    logic [LENGTH-1:0]     out_data;
    logic [FIELD_W-1:0]    out_field;
    logic [ADDR_WIDTH-1:0] out_row;
    logic                  out_is_y;
    logic                  out_last_row_beat;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data, out_field, out_row, out_is_y, out_last_row_beat, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_field, out_row, out_is_y, out_last_row_beat, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/row_serializer.sv
// Holds one RAM row and walks it out a field at a time: features 0..n-1, then y.
// Outputs read as zero whenever the stream is not active.
module row_serializer
    import ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [FIELD_W-1:0]    i_num_features,
    input  logic                  i_active,
    input  logic                  i_advance,
    output logic [LENGTH-1:0]     o_data,
    output logic [FIELD_W-1:0]    o_field,
    output logic                  o_is_y,
    output logic                  o_last_row_beat
);
    logic [DATA_WIDTH-1:0] r_buf;
    logic [FIELD_W-1:0]    r_beat;
    logic                  w_is_y;
    logic [FIELD_W-1:0]    w_field;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_buf <= i_word;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_beat <= '0;
        end else if (i_load) begin
            r_beat <= '0;
        end else if (i_advance && !w_is_y) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    // The beat after the last feature is y, wherever y sits in the word.
    assign w_is_y  = (r_beat == i_num_features);
    assign w_field = w_is_y ? Y_FIELD : r_beat;

    always_comb begin
        o_data          = '0;
        o_field         = '0;
        o_is_y          = 1'b0;
        o_last_row_beat = 1'b0;
        if (i_active) begin
            o_data          = r_buf[int'(w_field)*LENGTH +: LENGTH];
            o_field         = w_field;
            o_is_y          = w_is_y;
            o_last_row_beat = w_is_y;
        end
    end
endmodule

// File: rtl/ram_row_streamer.sv
// Read-side RAM master: walks a row range, holds each address for RD_LAT cycles,
// captures the word and hands it to row_serializer for one-field-per-beat streaming.
module ram_row_streamer
    import ram_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_num_rows,
    input  logic [FIELD_W-1:0]    i_num_features,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_oe,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    ram_row_streamer_if.master    strm,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_LAST = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_num_rows;
    logic [ADDR_WIDTH:0]   r_row;
    logic [FIELD_W-1:0]    r_nf;
    logic [2:0]            r_wait;

    logic                  w_valid;
    logic                  w_hs;
    logic                  w_wait_done;
    logic                  w_load;
    logic                  w_rows_last;
    logic                  w_row_end;
    logic [LENGTH-1:0]     w_data;
    logic [FIELD_W-1:0]    w_field;
    logic                  w_is_y;

    assign w_valid     = (r_state == S_STREAM);
    assign w_hs        = w_valid && strm.out_ready;
    assign w_wait_done = (r_wait == WAIT_LAST);
    assign w_rows_last = ((r_row + 1'b1) == r_num_rows);
    // The word is sampled on the edge that ends the final cycle of address hold.
    assign w_load      = ((r_state == S_ADDR) && (RD_LAT == 1)) ||
                         ((r_state == S_WAIT) && w_wait_done);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_rows == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR:   w_next = (RD_LAT == 1) ? S_STREAM : S_WAIT;
            S_WAIT: begin
                if (w_wait_done) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_hs && w_row_end) begin
                    w_next = w_rows_last ? S_DONE : S_ADDR;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_base     <= '0;
            r_num_rows <= '0;
            r_row      <= '0;
            r_nf       <= '0;
            r_wait     <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_base     <= i_base_addr;
                r_num_rows <= i_num_rows;
                r_row      <= '0;
                r_nf       <= sat_features(i_num_features);
            end
            if (r_state == S_ADDR) begin
                r_wait <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait <= r_wait + 3'd1;
            end
            if (w_hs && w_row_end && !w_rows_last) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    row_serializer u_ser (
        .clk             (clk),
        .RST             (RST),
        .i_load          (w_load),
        .i_word          (i_ram_rdata),
        .i_num_features  (r_nf),
        .i_active        (w_valid),
        .i_advance       (w_hs),
        .o_data          (w_data),
        .o_field         (w_field),
        .o_is_y          (w_is_y),
        .o_last_row_beat (w_row_end)
    );

    // Address wraps modulo 2^ADDR_WIDTH; out_row stays the unwrapped offset.
    assign o_ram_addr  = r_base + r_row[ADDR_WIDTH-1:0];
    assign o_ram_oe    = (r_state == S_ADDR) || (r_state == S_WAIT);
    assign o_ram_we    = 1'b0;
    assign o_busy      = (r_state == S_ADDR) || (r_state == S_WAIT) || (r_state == S_STREAM);
    assign o_done      = (r_state == S_DONE);
    assign o_dbg_state = r_state;

    assign strm.out_valid         = w_valid;
    assign strm.out_data          = w_data;
    assign strm.out_field         = w_field;
    assign strm.out_is_y          = w_is_y;
    assign strm.out_last_row_beat = w_row_end;
    assign strm.out_last          = w_row_end && w_rows_last;
    assign strm.out_row           = w_valid ? r_row[ADDR_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_ram_row_streamer.sv
// Bench for ram_row_streamer: table of passes plus random passes, each checked
// beat-by-beat against a row/field model built from the RAM contents.
module tb_ram_row_streamer;
    import ram_pkg::*;

    localparam int RD_LAT = 2;
    localparam int BW     = LENGTH + FIELD_W + ADDR_WIDTH + 3;

    logic                  clk = 1'b0;
    logic                  RST = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [ADDR_WIDTH:0]   num_rows = '0;
    logic [FIELD_W-1:0]    num_features = '0;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_oe, ram_we, busy, done;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [2:0]            dbg_state;

    ram_row_streamer_if sif ();

    ram_row_streamer #(.RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .RST            (RST),
        .i_start        (start),
        .i_base_addr    (base_addr),
        .i_num_rows     (num_rows),
        .i_num_features (num_features),
        .o_ram_addr     (ram_addr),
        .o_ram_oe       (ram_oe),
        .o_ram_we       (ram_we),
        .i_ram_rdata    (ram_rdata),
        .strm           (sif),
        .o_busy         (busy),
        .o_done         (done),
        .o_dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // RAM model: data is only good once the address has been held RD_LAT cycles.
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [2:0]            oe_cnt = '0;
    always @(posedge clk) oe_cnt <= ram_oe ? ((oe_cnt == 3'd7) ? oe_cnt : oe_cnt + 3'd1) : 3'd0;
    assign ram_rdata = (ram_oe && (oe_cnt >= 3'(RD_LAT - 1))) ? mem[ram_addr] : {(DATA_WIDTH/16){16'hDEAD}};

    int errors = 0, checks = 0, cyc = 0;
    int beats, done_cnt, first_valid, last_hs, gap_from, oe_rises, rel, start_cyc, cur_rows;
    int ready_mode = 0;
    logic mon_en = 1'b0, prev_oe, prev_valid, prev_stall;
    logic [BW-1:0] prev_pack, cur;
    logic [BW-1:0] exp_q[$];
    logic [ADDR_WIDTH-1:0] exp_addr_q[$];
    logic [BW-1:0] beat_log[$];
    logic [ADDR_WIDTH-1:0] addr_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Expected stream: per row, features 0..n-1 then y; addresses wrap mod 2^ADDR_WIDTH.
    task automatic build_model(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] n,
                               input logic [FIELD_W-1:0] nf);
        int nfi;
        nfi = (int'(nf) > MAX_FEATURES) ? MAX_FEATURES : int'(nf);
        exp_q.delete();
        exp_addr_q.delete();
        for (int r = 0; r < int'(n); r++) begin
            logic [ADDR_WIDTH-1:0] a;
            a = ADDR_WIDTH'((int'(base) + r) % (1 << ADDR_WIDTH));
            exp_addr_q.push_back(a);
            for (int k = 0; k <= nfi; k++) begin
                int fld;
                logic y;
                fld = (k == nfi) ? MAX_FEATURES : k;
                y = (k == nfi);
                exp_q.push_back({mem[a][fld*LENGTH +: LENGTH], FIELD_W'(fld), ADDR_WIDTH'(r),
                                 y, y, y && (r == int'(n) - 1)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            rel = cyc - start_cyc;
            cur = {sif.out_data, sif.out_field, sif.out_row, sif.out_is_y, sif.out_last_row_beat, sif.out_last};
            if (ram_oe && !prev_oe) begin
                oe_rises++;
                addr_log.push_back(ram_addr);
                if (exp_addr_q.size() == 0) fail_now("extra_oe");
                else check("ram_addr", ram_addr, exp_addr_q.pop_front());
            end
            if (prev_stall) begin
                check("stall_hold", cur, prev_pack);
                check("stall_valid", sif.out_valid, 1);
            end
            if (sif.out_valid && !prev_valid) begin
                if (first_valid < 0) first_valid = rel;
                if (gap_from >= 0) begin
                    check("row_gap", rel, gap_from + RD_LAT + 1);
                    gap_from = -1;
                end
            end
            if (sif.out_valid && sif.out_ready) begin
                beats++;
                beat_log.push_back(cur);
                if (exp_q.size() == 0) fail_now("extra_beat");
                else check("beat", cur, exp_q.pop_front());
                check("ram_we", ram_we, 0);
                if (sif.out_last) last_hs = rel;
                else if (sif.out_last_row_beat) gap_from = rel;
            end
            if (done) begin
                done_cnt++;
                check("done_cycle", rel, (cur_rows == 0) ? 1 : last_hs + 1);
                check("done_busy", busy, 0);
            end
            prev_oe    = ram_oe;
            prev_valid = sif.out_valid;
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_pack  = cur;
        end
    end

    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       sif.out_ready = ($urandom_range(0, 1) == 1);
                2:       sif.out_ready = ($urandom_range(0, 3) == 0);
                default: sif.out_ready = 1'b1;
            endcase
        end
    end

    task automatic start_pass(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] n,
                              input logic [FIELD_W-1:0] nf, input int rmode);
        build_model(base, n, nf);
        @(negedge clk);
        #1;
        ready_mode = rmode;
        beats = 0; done_cnt = 0; first_valid = -1; last_hs = -1; gap_from = -1; oe_rises = 0;
        prev_oe = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0; prev_pack = '0;
        beat_log.delete();
        addr_log.delete();
        cur_rows = int'(n);
        start = 1'b1; base_addr = base; num_rows = n; num_features = nf;
        start_cyc = cyc;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] n,
                            input logic [FIELD_W-1:0] nf, input int rmode, input int exp_beats,
                            input bit spam);
        int guard;
        start_pass(base, n, nf, rmode);
        guard = 0;
        while (done_cnt == 0 && guard < 4000) begin
            if (spam) begin
                start        = ($urandom_range(0, 1) == 1);
                base_addr    = ADDR_WIDTH'($urandom);
                num_rows     = (ADDR_WIDTH+1)'($urandom_range(0, 9));
                num_features = FIELD_W'($urandom);
            end
            @(negedge clk);
            #1;
            guard++;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("done_count", done_cnt, 1);
        check("beat_count", beats, exp_beats);
        check("model_left", exp_q.size(), 0);
        check("oe_rows", oe_rises, int'(n));
        if (n != 0) check("first_valid", first_valid, RD_LAT + 1);
        mon_en = 1'b0;
    endtask

    typedef struct {
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH:0]   nrows;
        logic [FIELD_W-1:0]    nf;
        int                    rmode;
        int                    exp_beats;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen, guard, n, nf;
        logic [15:0] sr_exp[4];
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = {8{$urandom()}};
        for (int k = 0; k <= MAX_FEATURES; k++) mem[5][k*LENGTH +: LENGTH] = 16'(k);

        vecs[0] = '{12'd5,    13'd1, 4'd3,  0, 4};
        vecs[1] = '{12'd100,  13'd2, 4'd15, 1, 32};
        vecs[2] = '{12'hFFF,  13'd2, 4'd4,  0, 10};
        vecs[3] = '{12'd7,    13'd0, 4'd5,  0, 0};
        vecs[4] = '{12'd20,   13'd3, 4'd0,  1, 3};
        vecs[5] = '{12'd4094, 13'd4, 4'd1,  2, 8};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", ram_addr, 0);
        check("rst_oe", ram_oe, 0);
        check("rst_we", ram_we, 0);
        check("rst_data", sif.out_data, 0);
        check("rst_field", sif.out_field, 0);
        check("rst_row", sif.out_row, 0);
        check("rst_flags", {sif.out_is_y, sif.out_last_row_beat, sif.out_last}, 0);
        check("rst_valid", sif.out_valid, 0);
        check("rst_busy_done", {busy, done}, 0);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i].base, vecs[i].nrows, vecs[i].nf, vecs[i].rmode, vecs[i].exp_beats, 1'b0);
        end

        // Single row at address 5 holding field k = k.
        sr_exp = '{16'h0000, 16'h0001, 16'h0002, 16'h000F};
        run_pass(12'd5, 13'd1, 4'd3, 0, 4, 1'b0);
        for (int i = 0; i < 4; i++) check("single_data", beat_log[i][BW-1 -: LENGTH], sr_exp[i]);
        check("single_y_last", {beat_log[3][2], beat_log[3][0]}, 2'b11);
        check("single_not_y", beat_log[2][2], 0);

        // Wrap across the top of the address space.
        run_pass(12'hFFF, 13'd2, 4'd1, 0, 4, 1'b0);
        check("wrap_addr0", addr_log[0], 12'hFFF);
        check("wrap_addr1", addr_log[1], 12'h000);
        check("wrap_row0", beat_log[0][ADDR_WIDTH+2:3], 0);
        check("wrap_row1", beat_log[2][ADDR_WIDTH+2:3], 1);

        // start and the pass inputs wiggling while busy.
        run_pass(12'd300, 13'd3, 4'd2, 1, 9, 1'b1);

        // Reset during the second row's stream.
        start_pass(12'd40, 13'd3, 4'd2, 0);
        guard = 0;
        while (!(sif.out_valid && sif.out_row == 1) && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("rst_reach_row1", sif.out_row, 1);
        mon_en = 1'b0;
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
        check("abort_valid", sif.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_oe", ram_oe, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || sif.out_valid) seen++;
        end
        check("abort_quiet", seen, 0);
        run_pass(12'd41, 13'd2, 4'd2, 0, 6, 1'b0);

        for (int i = 0; i < 10; i++) begin
            n  = $urandom_range(1, 3);
            nf = $urandom_range(0, MAX_FEATURES);
            run_pass(ADDR_WIDTH'($urandom), (ADDR_WIDTH+1)'(n), FIELD_W'(nf), $urandom_range(0, 2),
                     n * (nf + 1), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ram_row_streamer.md
# ram_row_streamer

Read-side master for the dataset RAM. On `start` it walks a contiguous range of RAM rows. Each row holds up to `MAX_FEATURES` features plus one y value, each `LENGTH` bits wide. The block serialises every row into a valid/ready stream of one field per beat, and that stream feeds the regression datapath. It is the only initiator driving the RAM's `addr`/`oe`/`we` pins during training passes.

## Interface
- `ADDR_WIDTH`, 12: RAM address width.
- `MAX_FEATURES`, 15: feature slots per row.
- `LENGTH`, 16: bits per field.
- `DATA_WIDTH`, `LENGTH*(MAX_FEATURES+1)`: RAM word width.
- `RD_LAT`, 2: cycles `ram_addr`/`ram_oe` are held before the word is sampled; legal range 1..7.
- `clk` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `start` in 1: begin a pass; sampled only in IDLE.
- `base_addr` in `ADDR_WIDTH`: first row address; captured on `start`.
- `num_rows` in `ADDR_WIDTH+1`: rows to read, 0..2^ADDR_WIDTH; captured on `start`.
- `num_features` in 4: features emitted per row, 0..`MAX_FEATURES`; values above the maximum saturate to `MAX_FEATURES`; captured on `start`.
- `ram_addr` out `ADDR_WIDTH`: RAM address.
- `ram_oe` out 1: RAM output enable.
- `ram_we` out 1: RAM write enable; constant 0.
- `ram_rdata` in `DATA_WIDTH`: RAM data bus (read side of the inout).
- `out_data` out `LENGTH`: current field.
- `out_field` out 4: field index; `MAX_FEATURES` marks y.
- `out_row` out `ADDR_WIDTH`: row offset from `base_addr`.
- `out_is_y`, `out_last_row_beat`, `out_last` out 1 each: y beat; last beat of the row; last beat of the pass.
- `out_valid` out 1 / `out_ready` in 1: stream handshake.
- `busy`, `done` out 1: pass in progress; one-cycle completion pulse.

## Operation
- Field k of a RAM word is `ram_rdata[k*LENGTH +: LENGTH]`. Field `MAX_FEATURES` is y.
- Per row the block emits fields 0..`num_features`-1, then y. That is `num_features`+1 beats. With `num_features`=0 only y is emitted.
- FSM states: IDLE, ADDR, WAIT, STREAM, DONE.
  - IDLE to ADDR on `start`. If the captured `num_rows`=0, go IDLE to DONE instead.
  - ADDR drives `ram_addr`=`base_addr`+row and `ram_oe`=1, then goes to WAIT.
  - WAIT holds the address and `ram_oe` for `RD_LAT`-1 further cycles. The row buffer loads on the edge that ends the last WAIT cycle; with `RD_LAT`=1 it loads on the edge that ends ADDR. The next state is STREAM, with `ram_oe` dropped.
  - STREAM presents beats from the buffer. On the handshake of the last beat of a row: if rows remain, increment the row and go to ADDR; otherwise go to DONE.
  - DONE pulses `done` for one cycle, then returns to IDLE.
- Address arithmetic is modulo 2^`ADDR_WIDTH`: rows past the top wrap to 0. `out_row` is the unwrapped offset, truncated to `ADDR_WIDTH` bits.
- Stream rules:
  - While `out_valid`=1 and `out_ready`=0, all `out_*` signals hold stable.
  - `out_valid` never depends combinationally on `out_ready`.
- `start` is ignored while `busy`=1.
- `RST` in any state returns to IDLE on the next edge and aborts the pass. No further beats or `done` follow.

## Timing
- Reset values: `ram_addr`=0, `ram_oe`=0, `ram_we`=0, `out_data`=0, `out_field`=0, `out_row`=0, all flags 0, `out_valid`=0, `busy`=0, `done`=0. The row buffer is not reset.
- Start latency: `start` is sampled at edge 0.
  - `ram_oe`=1 during cycles 1..`RD_LAT`.
  - First `out_valid`=1 in cycle `RD_LAT`+1.
- Throughput: 1 beat per cycle within a row while `out_ready`=1.
- Row gap: `RD_LAT`+1 cycles between the last-beat handshake of one row and the first `out_valid` of the next.
- `busy` is 1 from cycle 1 through the cycle before `done`. `done` asserts in the cycle after the final handshake; `busy` is 0 in that cycle.
- `out_last` and `out_last_row_beat` are both 1 on the final beat of the pass.

## Structure
- Shared package `ram_pkg` holds `LENGTH`, `MAX_FEATURES`, `DATA_WIDTH`, `ADDR_WIDTH`, and a field-index constant `Y_FIELD`=`MAX_FEATURES`. The RAM and this block both use it.
- The FSM state enum is local to the block.
- One sub-module, `row_serializer`, holds the `DATA_WIDTH` row buffer, the field counter, the field mux and the per-row last/is_y flags. The top level holds the FSM, row counter, address adder and `done`/`busy`.

## Test plan
- Single row: RAM[5] = fields 0..15 set to 0x0000..0x000F. Run `base_addr`=5, `num_rows`=1, `num_features`=3, `out_ready`=1, `RD_LAT`=2. Required: beats 0x0000, 0x0001, 0x0002 then 0x000F with `out_is_y`=1, `out_last`=1; first `out_valid` in cycle 3; `done` in the cycle after the last beat.
- Back-pressure: 2 rows, `num_features`=15. Toggle `out_ready` pseudo-randomly. Required: 32 beats in order, stable outputs while stalled, `ram_we`=0 throughout.
- Wrap: `base_addr`=0xFFF, `num_rows`=2. Required: `ram_addr` reads 0xFFF then 0x000; `out_row` is 0 then 1.
- Empty and saturating: `num_rows`=0 gives `done` in cycle 1, no `ram_oe`, no beats. `num_features`=0 gives one y beat per row.
- Reset mid-pass: assert `RST` during the second row's STREAM. Required: next cycle `out_valid`=0, `busy`=0, `ram_oe`=0, and no `done`. A new `start` then works normally.
- `start` pulsed while `busy`: no effect on address sequence or beat count.
